// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the fetch/sequencing stage: state
//               encodings, bus widths, instruction-word field positions and
//               the indirect-reference decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    // Instruction word layout: [15] I bit, [14:12] opcode, [11:0] address
    localparam int IR_I_BIT   = 15;
    localparam int IR_OPC_HI  = 14;
    localparam int IR_OPC_LO  = 12;
    localparam int IR_ADDR_HI = 11;

    // Opcode 7 marks register/IO-reference words; their I bit is not an
    // indirect flag.
    localparam logic [2:0] OPC_REG_REF = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_INDIRECT = 3'd3,
        ST_EXEC     = 3'd4
    } fetch_state_t;

    function automatic logic is_indirect(input logic [DATA_W-1:0] ir);
        return ir[IR_I_BIT] && (ir[IR_OPC_HI:IR_OPC_LO] != OPC_REG_REF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Memory read handshake between the fetch unit and the shared
//               memory. mem_req is held until mem_ready is seen.
//   master : mem_req, mem_addr out; mem_ready, mem_rdata in (fetch unit)
//   slave  : mem_req, mem_addr in;  mem_ready, mem_rdata out (memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr,
                    input  mem_ready, input mem_rdata);
    modport slave  (input  mem_req, input mem_addr,
                    output mem_ready, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_counter
// Description : 4-bit sequence counter, synchronous clear (priority over
//               enable), counts when enabled, saturates at 15.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clr        : synchronous clear to 0
//   i_en         : count enable
//   o_count      : current count
// Revision    : 1.0 - initial release
// ============================================================================
module seq_counter (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       i_clr,
    input  wire logic       i_en,
    output logic      [3:0] o_count
);
    logic [3:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_en && (r_count != 4'hF)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch and sequencing stage. Owns PC, AR, IR and
//               the sequence counter; fetches over the memory handshake,
//               optionally resolves indirect addresses, then holds IR/AR for
//               the control unit until end-of-instruction (i_clr_sc), where
//               branch/skip PC updates are applied.
//   Build option : FETCH_INDIRECT_EN - when defined, indirect memory-reference
//                  words take an extra INDIRECT read to resolve AR; otherwise
//                  DECODE always proceeds to EXEC with AR = IR[11:0].
//   clk, reset_n     : clock, asynchronous active-low reset
//   i_start          : leave IDLE and fetch at PC
//   i_clr_sc         : end-of-instruction pulse (EXEC only), qualifies
//                      i_halt / i_branch / i_branch_addr / i_skip
//   mem              : memory read handshake (master)
//   o_ir, o_ar, o_pc : instruction, effective address, program counter
//   o_ir_valid       : IR/AR stable for the control unit (EXEC)
//   o_sc             : sequence counter
//   o_is_idle        : unit is in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              ADDR_W   = cpu_pkg::ADDR_W,
    parameter int              DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              i_start,
    input  wire logic              i_halt,
    input  wire logic              i_clr_sc,
    input  wire logic              i_branch,
    input  wire logic [ADDR_W-1:0] i_branch_addr,
    input  wire logic              i_skip,
    fetch_unit_if.master           mem,
    output logic      [DATA_W-1:0] o_ir,
    output logic      [ADDR_W-1:0] o_ar,
    output logic      [ADDR_W-1:0] o_pc,
    output logic                   o_ir_valid,
    output logic      [3:0]        o_sc,
    output logic                   o_is_idle
);
    import cpu_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ar;
    logic [DATA_W-1:0] r_ir;
    logic              w_sc_clr;
    logic              w_sc_en;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem.mem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
`ifdef FETCH_INDIRECT_EN
                w_next = is_indirect(r_ir) ? ST_INDIRECT : ST_EXEC;
`else
                w_next = ST_EXEC;
`endif
            end
            ST_INDIRECT: begin
                if (mem.mem_ready) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (i_clr_sc) w_next = i_halt ? ST_IDLE : ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // PC / AR / IR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_ar <= '0;
            r_ir <= '0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (mem.mem_ready) begin
                        r_ir <= mem.mem_rdata;
                        r_pc <= r_pc + 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_ar <= r_ir[ADDR_W-1:0];
                end
                ST_INDIRECT: begin
                    if (mem.mem_ready) r_ar <= mem.mem_rdata[ADDR_W-1:0];
                end
                ST_EXEC: begin
                    // Branch wins over skip; skip adds to the PC already
                    // advanced during FETCH.
                    if (i_clr_sc) begin
                        if (i_branch)    r_pc <= i_branch_addr;
                        else if (i_skip) r_pc <= r_pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequence counter: cleared on every entry into FETCH, counts in all
    // non-IDLE states.
    // ------------------------------------------------------------------
    assign w_sc_clr = (w_next == ST_FETCH) && (r_state != ST_FETCH);
    assign w_sc_en  = (r_state != ST_IDLE);

    seq_counter u_seq_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_sc_clr),
        .i_en    (w_sc_en),
        .o_count (o_sc)
    );

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign mem.mem_req  = (r_state == ST_FETCH) || (r_state == ST_INDIRECT);
    assign mem.mem_addr = (r_state == ST_INDIRECT) ? r_ar : r_pc;
    assign o_ir_valid   = (r_state == ST_EXEC);
    assign o_is_idle    = (r_state == ST_IDLE);
    assign o_ir         = r_ir;
    assign o_ar         = r_ar;
    assign o_pc         = r_pc;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage directly upstream of the control unit. It owns PC, AR, IR and the sequence counter (SC), and fetches each instruction word from the shared memory over a request/ready handshake. For indirect memory-reference instructions it resolves the effective address. It then presents a stable IR/AR to the control unit until that unit signals end-of-instruction. PC update for branch/skip is applied at that hand-back.

## Interface
- ADDR_W, 12, memory address / PC / AR width
- DATA_W, 16, memory word and IR width
- RESET_PC, 12'h000, PC value after reset
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  begin fetching at PC; sampled only in IDLE
- i_halt  in  1  with i_clr_sc: return to IDLE instead of fetching next
- i_clr_sc  in  1  end-of-instruction from control unit (1-cycle pulse)
- i_branch  in  1  with i_clr_sc: PC <= i_branch_addr
- i_branch_addr  in  ADDR_W  branch target
- i_skip  in  1  with i_clr_sc: PC <= PC+1 (ISZ skip)
- i_mem_ready  in  1  memory read data valid this cycle
- i_mem_rdata  in  DATA_W  memory read data
- o_mem_req  out  1  read request, held until i_mem_ready
- o_mem_addr  out  ADDR_W  read address (PC in FETCH, AR in INDIRECT)
- o_ir  out  DATA_W  instruction register
- o_ar  out  ADDR_W  effective address
- o_pc  out  ADDR_W  program counter
- o_ir_valid  out  1  IR/AR stable and owned by control unit
- o_sc  out  4  sequence counter
- o_is_idle  out  1  high in IDLE

## Operation
- States: IDLE, FETCH, DECODE, INDIRECT, EXEC.
- IDLE: o_is_idle=1. i_start=1 -> FETCH, SC<=0.
- FETCH: o_mem_req=1, o_mem_addr=PC. On i_mem_ready: IR<=i_mem_rdata, PC<=PC+1, -> DECODE.
- DECODE: AR<=IR[11:0]. Indirect if IR[15]=1 and IR[14:12]!=3'd7 -> INDIRECT; else -> EXEC.
- INDIRECT: o_mem_req=1, o_mem_addr=AR. On i_mem_ready: AR<=i_mem_rdata[11:0], -> EXEC.
- EXEC: o_ir_valid=1. Waits for i_clr_sc. On i_clr_sc: PC update (i_branch beats i_skip; neither -> unchanged), then i_halt ? IDLE : FETCH with SC<=0.
- PC arithmetic modulo 2^ADDR_W: 12'hFFF+1 = 12'h000, both in FETCH and skip. FETCH increment and skip are independent: skip adds 1 to PC already advanced in FETCH.
- SC: +1 every edge outside IDLE. Cleared on entry to FETCH. Saturates at 15. Holds in IDLE.
- i_clr_sc outside EXEC: ignored. i_start outside IDLE: ignored.
- o_mem_req drops the cycle after the accepting i_mem_ready. Never asserted in DECODE, EXEC or IDLE.
- i_mem_ready without o_mem_req: ignored.
- Reset, including mid-fetch: state=IDLE, PC=RESET_PC, AR=0, IR=0, SC=0, o_mem_req=0, o_ir_valid=0, o_is_idle=1.

## Timing
- All registers update on the rising clk edge, except the asynchronous reset.
- o_mem_req, o_mem_addr, o_ir_valid and o_is_idle are decoded from state only. There is no combinational path from any input.
- Zero-wait memory, direct instruction: edge E0 samples i_start; E1 captures IR; E2 enters EXEC. o_ir_valid is high after E2 with SC=2.
- Indirect instruction: one extra state, so EXEC is entered after E3 with SC=3.
- Each wait cycle (i_mem_ready=0) adds one cycle and one SC count.
- Back-to-back: the edge of i_clr_sc enters FETCH. The next IR is valid 2 edges later (direct, zero-wait).

## Configuration
- FETCH_INDIRECT_EN defined: INDIRECT state present, behaving as above.
- FETCH_INDIRECT_EN not defined: DECODE always -> EXEC, AR=IR[11:0], IR[15] passed unchanged. The control unit performs the indirect read itself.

## Structure
- Shared package cpu_pkg: state enum encodings, ADDR_W/DATA_W constants, OPC_REG_REF=3'd7, and the IR field positions (I bit 15, opcode 14:12, address 11:0).
- One sub-module: seq_counter (4-bit, sync clear, enable, saturate at 15). The FSM and PC/AR/IR registers live in fetch_unit.

## Test plan
- Reset mid-FETCH while o_mem_req=1 -> all outputs at reset values in the same cycle. PC=RESET_PC, o_is_idle=1.
- mem[0]=16'h2005, i_start, ready tied high -> IR=16'h2005, AR=12'h005, PC=12'h001, o_ir_valid after 2 edges from start edge, SC=2.
- mem[0]=16'hA010, mem[0x010]=16'h0123 -> AR=12'h123, o_ir_valid with SC=3. With macro undefined: AR=12'h010, SC=2.
- i_mem_ready delayed 3 cycles in FETCH -> o_mem_req held 4 cycles, o_mem_addr stable, SC=5 at EXEC.
- PC=12'hFFF, fetch, then i_clr_sc with i_skip=1 -> PC wraps to 12'h000 after fetch, then 12'h001 after skip.
- i_clr_sc with i_branch=1, i_skip=1, i_branch_addr=12'h0F0 -> next o_mem_addr=12'h0F0. Same with i_halt=1 -> IDLE, PC=12'h0F0.
